reduce_acc: RTL and testbench

Streaming reduction stage that sits directly downstream of the single-cycle dataflow operators (AND/ADD/... immediates) and consumes their `R_OUT`/`D_OUT` stream. It sums a programmable number of valid elements and emits one registered result per group, with a one-cycle valid pulse, an overflow flag and an early-flush option. It is the first stage in the pipeline that holds multi-cycle state, so it is the point where per-element streams become per-group scalars.

---
 rtl/reduce_pkg.sv | 17 +
 rtl/reduce_acc_sat_add.sv | 27 ++
 rtl/reduce_acc.sv | 117 +++++++++++
 tb/tb_reduce_acc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduce_acc streaming reduction stage.
package reduce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam int SAT_MAX_W = 64;

  // All-ones value of width w, used as the saturation clamp.
  function automatic logic [SAT_MAX_W-1:0] sat_ones(input int w);
    if (w >= SAT_MAX_W) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/reduce_acc_sat_add.sv
// W-bit adder with carry out; clamps to all-ones on carry when
// REDUCE_ACC_SATURATE_EN is defined, otherwise wraps.
module sat_add
  import reduce_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];

`ifdef REDUCE_ACC_SATURATE_EN
  localparam logic [W-1:0] SAT = W'(sat_ones(W));
  // A clamped accumulator re-carries on any non-zero addend, so it stays clamped.
  assign sum = carry ? SAT : full[W-1:0];
`else
  assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/reduce_acc.sv
// Streaming group reducer: sums LEN accepted elements (or up to FLUSH) and
// emits one registered result per group. Optional macro: REDUCE_ACC_SATURATE_EN.
module reduce_acc
  import reduce_pkg::*;
#(
  parameter int N     = 16,
  parameter int W_ACC = 32,
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             R_IN,
  input  logic [N-1:0]     D_IN,
  input  logic [LEN_W-1:0] LEN,
  input  logic             FLUSH,
  output logic             R_OUT,
  output logic [W_ACC-1:0] D_OUT,
  output logic             OVF
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [W_ACC-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               r_out_q, r_out_d;
  logic [W_ACC-1:0]   d_out_q, d_out_d;
  logic               ovf_out_q, ovf_out_d;

  logic [W_ACC-1:0]   add_a, add_sum;
  logic               add_carry;
  logic [LEN_W-1:0]   len_new;
  logic               accept, emit;

  // Opening a group adds to zero, so the same adder serves load and accumulate.
  assign add_a   = (state_q == IDLE) ? '0 : acc_q;
  assign accept  = EN & R_IN;
  assign len_new = (LEN == '0) ? LEN_W'(1) : LEN;

  sat_add #(.W(W_ACC)) u_add (
    .a     (add_a),
    .b     (W_ACC'(D_IN)),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    d_out_d   = d_out_q;
    ovf_out_d = ovf_out_q;
    r_out_d   = 1'b0;
    emit      = 1'b0;
    if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            len_d = len_new;
            acc_d = add_sum;
            cnt_d = LEN_W'(1);
            ovf_d = add_carry;
            if (len_new == LEN_W'(1) || FLUSH) emit = 1'b1;
            else                               state_d = ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + LEN_W'(1);
            ovf_d = ovf_q | add_carry;
            if (cnt_q + LEN_W'(1) == len_q || FLUSH) emit = 1'b1;
          end else if (FLUSH) begin
            emit = 1'b1;
          end
          if (emit) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (emit) begin
      r_out_d   = 1'b1;
      d_out_d   = acc_d;
      ovf_out_d = ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      len_q     <= LEN_W'(1);
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      r_out_q   <= 1'b0;
      d_out_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      r_out_q   <= r_out_d;
      d_out_q   <= d_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign R_OUT = r_out_q;
  assign D_OUT = d_out_q;
  assign OVF   = ovf_out_q;

endmodule

// File: tb/tb_reduce_acc.sv
// Directed bench for reduce_acc with a group-level reference model and
// literal checks of each test's emitted results.
module tb_reduce_acc;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int LW = 16;

  logic          CLK = 1'b0;
  logic          RST, EN, R_IN, FLUSH;
  logic [N-1:0]  D_IN;
  logic [LW-1:0] LEN;
  logic          R_OUT;
  logic [W-1:0]  D_OUT;
  logic          OVF;

  always #5 CLK = ~CLK;

  reduce_acc #(.N(N), .W_ACC(W), .LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D_IN),
    .LEN(LEN), .FLUSH(FLUSH), .R_OUT(R_OUT), .D_OUT(D_OUT), .OVF(OVF)
  );

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Group-level model: the open group is just a target length, an element
  // count and the exact (unbounded) running total.
  bit           m_open  = 1'b0;
  int           m_tgt   = 0;
  int           m_k     = 0;
  longint       m_total = 0;
  bit           exp_r   = 1'b0;
  logic [W-1:0] exp_d   = '0;
  bit           exp_o   = 1'b0;

  logic [W-1:0] got_d[$];
  bit           got_o[$];

  function automatic logic [W-1:0] grp_result(input longint t);
    if (t >= 65536) begin
`ifdef REDUCE_ACC_SATURATE_EN
      return 16'hFFFF;
`else
      return W'(t % 65536);
`endif
    end
    return W'(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) begin : model
    bit           open, r, emit, o;
    int           tgt, k;
    longint       tot;
    logic [W-1:0] d;
    open = m_open; tgt = m_tgt; k = m_k; tot = m_total;
    r = 1'b0; emit = 1'b0; d = exp_d; o = exp_o;
    if (RST) begin
      open = 1'b0; d = '0; o = 1'b0;
    end else if (EN) begin
      if (R_IN) begin
        if (!open) begin
          open = 1'b1; tgt = (LEN == 0) ? 1 : int'(LEN); k = 0; tot = 0;
        end
        tot  = tot + longint'(D_IN);
        k    = k + 1;
        emit = (k == tgt) || FLUSH;
      end else if (FLUSH && open) begin
        emit = 1'b1;
      end
      if (emit) begin
        r = 1'b1; d = grp_result(tot); o = (tot >= 65536); open = 1'b0;
      end
    end
    m_open  <= open;
    m_tgt   <= tgt;
    m_k     <= k;
    m_total <= tot;
    exp_r   <= r;
    exp_d   <= d;
    exp_o   <= o;
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("r_out", 64'(R_OUT), 64'(exp_r));
      chk("d_out", 64'(D_OUT), 64'(exp_d));
      chk("ovf",   64'(OVF),   64'(exp_o));
      if (R_OUT === 1'b1) begin
        got_d.push_back(D_OUT);
        got_o.push_back(OVF);
      end
    end
  end

  task automatic step(input bit en, input bit r, input logic [15:0] d,
                      input logic [15:0] len, input bit fl);
    EN = en; R_IN = r; D_IN = d; LEN = len; FLUSH = fl;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
  endtask

  // Literal expectations for the pulses of one test, then clear the capture.
  task automatic pulses(input string nm, input int n, input logic [15:0] d0,
                        input logic [15:0] d1, input bit o0);
    idle(2);
    chk({nm, " count"}, 64'(got_d.size()), 64'(n));
    if (n > 0) begin
      chk({nm, " d0"}, (got_d.size() > 0) ? 64'(got_d[0]) : {64{1'bx}}, 64'(d0));
      chk({nm, " o0"}, (got_o.size() > 0) ? 64'(got_o[0]) : {64{1'bx}}, 64'(o0));
    end
    if (n > 1)
      chk({nm, " d1"}, (got_d.size() > 1) ? 64'(got_d[1]) : {64{1'bx}}, 64'(d1));
    got_d.delete();
    got_o.delete();
  endtask

  initial begin
    RST = 1'b1;
    step(1'b1, 1'b1, 16'd7, 16'd1, 1'b0);
    armed = 1'b1;
    step(1'b1, 1'b1, 16'd7, 16'd1, 1'b1);
    chk("reset r_out", 64'(R_OUT), 64'd0);
    chk("reset d_out", 64'(D_OUT), 64'd0);
    chk("reset ovf",   64'(OVF),   64'd0);
    RST = 1'b0;
    idle(1);

    // Basic group
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(i), 16'd4, 1'b0);
    pulses("basic", 1, 16'd10, 16'd0, 1'b0);

    // Back-to-back groups
    for (int i = 5; i <= 8; i++) step(1'b1, 1'b1, 16'(i), 16'd2, 1'b0);
    pulses("b2b", 2, 16'd11, 16'd15, 1'b0);

    // LEN changing mid-group is ignored
    step(1'b1, 1'b1, 16'd3, 16'd2, 1'b0);
    step(1'b1, 1'b1, 16'd4, 16'd7, 1'b0);
    pulses("len_hold", 1, 16'd7, 16'd0, 1'b0);

    // LEN=0 acts as 1
    step(1'b1, 1'b1, 16'd9, 16'd0, 1'b0);
    pulses("len0", 1, 16'd9, 16'd0, 1'b0);

    // Stall: element presented with EN low is not accepted
    step(1'b1, 1'b1, 16'd1,   16'd3, 1'b0);
    step(1'b0, 1'b1, 16'd100, 16'd3, 1'b0);
    step(1'b1, 1'b1, 16'd2,   16'd3, 1'b0);
    step(1'b1, 1'b1, 16'd3,   16'd3, 1'b0);
    pulses("stall", 1, 16'd6, 16'd0, 1'b0);

    // Flush alone, then flush with an element
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd1, 16'd8, 1'b0);
    step(1'b1, 1'b0, 16'd0, 16'd8, 1'b1);
    step(1'b1, 1'b1, 16'd4, 16'd8, 1'b0);
    step(1'b1, 1'b1, 16'd4, 16'd8, 1'b1);
    pulses("flush", 2, 16'd3, 16'd8, 1'b0);

    // Flush in IDLE, and flush with EN low mid-group
    step(1'b1, 1'b0, 16'd0, 16'd8, 1'b1);
    step(1'b1, 1'b1, 16'd5, 16'd8, 1'b0);
    step(1'b0, 1'b0, 16'd0, 16'd8, 1'b1);
    idle(1);
    chk("stalled flush", 64'(got_d.size()), 64'd0);
    step(1'b1, 1'b0, 16'd0, 16'd8, 1'b1);
    pulses("flush_idle", 1, 16'd5, 16'd0, 1'b0);

    // Overflow
    step(1'b1, 1'b1, 16'hFFFF, 16'd2, 1'b0);
    step(1'b1, 1'b1, 16'h0002, 16'd2, 1'b0);
`ifdef REDUCE_ACC_SATURATE_EN
    pulses("ovf", 1, 16'hFFFF, 16'd0, 1'b1);
`else
    pulses("ovf", 1, 16'h0001, 16'd0, 1'b1);
`endif

    // Next group after overflow starts clean
    step(1'b1, 1'b1, 16'd2, 16'd1, 1'b0);
    pulses("ovf_clear", 1, 16'd2, 16'd0, 1'b0);

    // Reset mid-group discards the partial sum
    step(1'b1, 1'b1, 16'd3, 16'd4, 1'b0);
    step(1'b1, 1'b1, 16'd3, 16'd4, 1'b0);
    RST = 1'b1;
    step(1'b1, 1'b1, 16'd3, 16'd4, 1'b1);
    RST = 1'b0;
    chk("rst d_out", 64'(D_OUT), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'd2, 16'd4, 1'b0);
    pulses("rst_mid", 1, 16'd8, 16'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
